volume_adjust_stage: RTL and testbench

Pipelined digital volume control for the I2S playback path. Sits between the sample buffer and the I2S transmitter. It multiplies each signed PCM sample by an unsigned volume code, scales the product, and saturates the result back to sample width. An optional ramp smooths volume changes to avoid zipper noise.

---
 rtl/volume_adjust_stage.sv | 144 ++++++++++++++
 tb/tb_volume_adjust_stage.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/volume_adjust_stage.sv
// -----------------------------------------------------------------------------
// volume_adjust_stage
//
// Pipelined digital volume control for the I2S playback path. Each signed PCM
// sample is multiplied by an unsigned gain code and shifted right by
// (VOLUME_BITS-1), so code 2^(VOLUME_BITS-1) is unity. The result is then
// saturated back to SAMPLE_BITS.
//
// Two register stages:
//   stage 1: product + valid
//   stage 2: shifted/saturated result -> sample_out / sample_out_valid
//
// Optional feature macro: VOLUME_ADJUST_RAMP_EN
//   defined   : gain steps by one code toward `volume` after every accepted
//               sample. Gain resets to 0 and never moves while no sample is
//               accepted.
//   undefined : gain loads `volume` every cycle. Reset loads `volume` too.
//
// Ports:
//   mclk             in   master clock (rising edge)
//   rst              in   synchronous active-high reset
//   sample_in        in   signed PCM sample, SAMPLE_BITS wide
//   sample_in_valid  in   sample_in accepted on every cycle this is high
//   volume           in   unsigned target gain code, VOLUME_BITS wide (>= 2)
//   sample_out       out  signed adjusted sample; holds while not valid
//   sample_out_valid out  one-cycle qualifier, two cycles after the input
// -----------------------------------------------------------------------------
module volume_adjust_stage #(
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 4
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic signed [SAMPLE_BITS-1:0] sample_in,
  input  logic                          sample_in_valid,
  input  logic        [VOLUME_BITS-1:0] volume,
  output logic signed [SAMPLE_BITS-1:0] sample_out,
  output logic                          sample_out_valid
);

  // One spare bit over the true product width keeps the zero-extended gain
  // positive inside a signed multiply.
  localparam int PROD_BITS = SAMPLE_BITS + VOLUME_BITS + 1;
  localparam int SHIFT     = VOLUME_BITS - 1;

  // Bits [PROD_BITS-1 : SAMPLE_BITS-1] of the shifted value. They must all
  // match for the value to fit in SAMPLE_BITS without clamping.
  localparam int HEAD_BITS = PROD_BITS - SAMPLE_BITS + 1;

  localparam logic signed [SAMPLE_BITS-1:0] SAT_MAX = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [SAMPLE_BITS-1:0] SAT_MIN = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Effective gain
  // ---------------------------------------------------------------------------
  logic [VOLUME_BITS-1:0] gain_reg;
  logic [VOLUME_BITS-1:0] gain_next;

`ifdef VOLUME_ADJUST_RAMP_EN
  localparam logic [VOLUME_BITS-1:0] GAIN_ONE = {{(VOLUME_BITS-1){1'b0}}, 1'b1};

  // A step is taken on the same edge that accepts a sample. That sample has
  // already captured the old gain, so the new value applies to the next one.
  always_comb begin
    gain_next = gain_reg;
    if (rst) begin
      gain_next = '0;
    end else if (sample_in_valid) begin
      if (gain_reg < volume) begin
        gain_next = gain_reg + GAIN_ONE;
      end else if (gain_reg > volume) begin
        gain_next = gain_reg - GAIN_ONE;
      end
    end
  end
`else
  // Registered so a volume change arriving with a sample only affects later
  // samples. This holds during reset as well.
  always_comb begin
    gain_next = volume;
  end
`endif

  always_ff @(posedge mclk) begin
    gain_reg <= gain_next;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: multiply
  // ---------------------------------------------------------------------------
  logic signed [PROD_BITS-1:0] sample_ext;
  logic signed [PROD_BITS-1:0] gain_ext;
  logic signed [PROD_BITS-1:0] prod_next;
  logic signed [PROD_BITS-1:0] prod_reg;
  logic                        valid1_reg;

  always_comb begin
    sample_ext = {{(VOLUME_BITS+1){sample_in[SAMPLE_BITS-1]}}, sample_in};
    gain_ext   = {{(SAMPLE_BITS+1){1'b0}}, gain_reg};
    prod_next  = sample_ext * gain_ext;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      prod_reg   <= '0;
      valid1_reg <= 1'b0;
    end else begin
      valid1_reg <= sample_in_valid;
      if (sample_in_valid) begin
        prod_reg <= prod_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: arithmetic shift (floor, no rounding) and saturate
  // ---------------------------------------------------------------------------
  logic signed [PROD_BITS-1:0]   shifted;
  logic        [HEAD_BITS-1:0]   head;
  logic signed [SAMPLE_BITS-1:0] sat_next;

  always_comb begin
    shifted  = prod_reg >>> SHIFT;
    head     = shifted[PROD_BITS-1:SAMPLE_BITS-1];
    sat_next = shifted[SAMPLE_BITS-1:0];
    if (!((&head) || !(|head))) begin
      // Out of range: the sign of the full value picks the rail.
      sat_next = shifted[PROD_BITS-1] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= valid1_reg;
      if (valid1_reg) begin
        sample_out <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_volume_adjust_stage.sv
// -----------------------------------------------------------------------------
// tb_volume_adjust_stage
//
// Scoreboard bench for volume_adjust_stage. On each accepted input, the
// expected output is queued together with the cycle it is due on. A
// negative-edge monitor checks every cycle:
//   - valid timing
//   - output data
//   - that sample_out holds between valid cycles
//
// Scenario tasks also compare the logged outputs against literal expected
// sequences. Define VOLUME_ADJUST_RAMP_EN to exercise the ramp build.
// -----------------------------------------------------------------------------
module tb_volume_adjust_stage;

  localparam int SB = 16;
  localparam int VB = 4;

  logic                 mclk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SB-1:0] sample_in = '0;
  logic                 sample_in_valid = 1'b0;
  logic        [VB-1:0] volume = '0;
  logic signed [SB-1:0] sample_out;
  logic                 sample_out_valid;

  volume_adjust_stage #(
    .SAMPLE_BITS(SB),
    .VOLUME_BITS(VB)
  ) dut (
    .mclk             (mclk),
    .rst              (rst),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .volume           (volume),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int exp;
    int due;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        out_log[$];
  int        cyc      = 0;
  int        gain_m   = 0;
  int        last_exp = 0;
  bit        mon_en   = 1'b0;
  int        n_assert = 0;
  int        n_fail   = 0;

  // Reference gain law: floor shift, then clamp.
  function automatic int model(int s, int g);
    int p;
    p = s * g;
    p = p >>> (VB - 1);
    if (p > (1 << (SB - 1)) - 1) p = (1 << (SB - 1)) - 1;
    if (p < -(1 << (SB - 1)))    p = -(1 << (SB - 1));
    return p;
  endfunction

  // Acceptance-edge model: queue the expected result and advance the gain.
  initial forever begin
    @(posedge mclk);
    cyc++;
    if (rst) begin
      sb.delete();
      last_exp = 0;
    end else if (sample_in_valid) begin
      sb.push_back('{exp: model(int'(sample_in), gain_m), due: cyc + 1});
    end
`ifdef VOLUME_ADJUST_RAMP_EN
    if (rst) begin
      gain_m = 0;
    end else if (sample_in_valid) begin
      if (gain_m < int'(volume))      gain_m++;
      else if (gain_m > int'(volume)) gain_m--;
    end
`else
    gain_m = int'(volume);
`endif
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge mclk);
    if (mon_en) begin
      bit                   exp_v;
      int                   exp_d;
      logic signed [SB-1:0] exp_s;

      while (sb.size() > 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
      end

      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      n_assert++;
      if (sample_out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL out_valid cycle %0d: got %b expected %b",
                 cyc, sample_out_valid, exp_v);
      end

      if (sample_out_valid === 1'b1) begin
        out_log.push_back(int'(sample_out));
      end

      exp_d = exp_v ? sb[0].exp : last_exp;
      exp_s = SB'(exp_d);
      n_assert++;
      if (sample_out !== exp_s) begin
        n_fail++;
        $display("FAIL out_data cycle %0d: got %0d expected %0d (%s)",
                 cyc, sample_out, exp_s, exp_v ? "new" : "hold");
      end

      if (exp_v) begin
        last_exp = exp_d;
        void'(sb.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only)
  // ---------------------------------------------------------------------------
  task automatic set_volume(int v);
    volume = VB'(v);
    @(negedge mclk);
  endtask

  task automatic send(int s);
    sample_in       = SB'(s);
    sample_in_valid = 1'b1;
    @(negedge mclk);
    sample_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge mclk);
      n++;
    end
    @(negedge mclk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst             = 1'b1;
    volume          = VB'(8);
    sample_in       = SB'(500);
    sample_in_valid = 1'b1;    // ignored while in reset
    repeat (3) @(negedge mclk);

    n_assert++;
    if (sample_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", sample_out_valid);
    end

    n_assert++;
    if (sample_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d expected 0", sample_out);
    end

    sample_in_valid = 1'b0;
    rst             = 1'b0;
    out_log.delete();
    mon_en = 1'b1;
    @(negedge mclk);
  endtask

  task automatic test_unity();
    int exp_a[] = '{1000, -1000};
    out_log.delete();
    set_volume(8);
    send(1000);
    send(-1000);
    drain();

    n_assert++;
    if (out_log.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL unity_count: got %0d expected %0d", out_log.size(), exp_a.size());
    end

    foreach (exp_a[i]) begin
      int got = (i < out_log.size()) ? out_log[i] : -99999;
      n_assert++;
      if (got != exp_a[i]) begin
        n_fail++;
        $display("FAIL unity[%0d]: got %0d expected %0d", i, got, exp_a[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_a[] = '{32767, -32768, 32767, -32768};
    out_log.delete();
    set_volume(15);
    send(30000);
    send(-30000);
    set_volume(8);
    send(32767);
    send(-32768);
    drain();

    n_assert++;
    if (out_log.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL sat_count: got %0d expected %0d", out_log.size(), exp_a.size());
    end

    foreach (exp_a[i]) begin
      int got = (i < out_log.size()) ? out_log[i] : -99999;
      n_assert++;
      if (got != exp_a[i]) begin
        n_fail++;
        $display("FAIL sat[%0d]: got %0d expected %0d", i, got, exp_a[i]);
      end
    end
  endtask

  task automatic test_mute_truncation();
    int exp_a[] = '{0, -2, 1};
    out_log.delete();
    set_volume(0);
    send(12345);
    set_volume(4);
    send(-3);
    send(3);
    drain();

    n_assert++;
    if (out_log.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL mute_trunc_count: got %0d expected %0d", out_log.size(), exp_a.size());
    end

    foreach (exp_a[i]) begin
      int got = (i < out_log.size()) ? out_log[i] : -99999;
      n_assert++;
      if (got != exp_a[i]) begin
        n_fail++;
        $display("FAIL mute_trunc[%0d]: got %0d expected %0d", i, got, exp_a[i]);
      end
    end
  endtask

  task automatic test_same_cycle_volume();
    // The volume change arrives with the first sample, so only the second
    // sample sees gain 15: 100*15 = 1500, and 1500 >>> 3 = 187.
    int exp_a[] = '{100, 187};
    out_log.delete();
    set_volume(8);
    sample_in       = SB'(100);
    sample_in_valid = 1'b1;
    volume          = VB'(15);
    @(negedge mclk);
    @(negedge mclk);
    sample_in_valid = 1'b0;
    drain();

    n_assert++;
    if (out_log.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL same_cycle_count: got %0d expected %0d", out_log.size(), exp_a.size());
    end

    foreach (exp_a[i]) begin
      int got = (i < out_log.size()) ? out_log[i] : -99999;
      n_assert++;
      if (got != exp_a[i]) begin
        n_fail++;
        $display("FAIL same_cycle[%0d]: got %0d expected %0d", i, got, exp_a[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_log.delete();
    set_volume(8);
    for (int i = 1; i <= 20; i++) begin
      sample_in       = SB'(i);
      sample_in_valid = 1'b1;
      @(negedge mclk);
    end
    sample_in_valid = 1'b0;
    drain();

    n_assert++;
    if (out_log.size() != 20) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 20", out_log.size());
    end

`ifndef VOLUME_ADJUST_RAMP_EN
    for (int i = 0; i < 20; i++) begin
      int got = (i < out_log.size()) ? out_log[i] : -99999;
      n_assert++;
      if (got != i + 1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %0d expected %0d", i, got, i + 1);
      end
    end
`endif
  endtask

  task automatic test_reset_midstream();
    out_log.delete();
    set_volume(8);
    for (int i = 1; i <= 10; i++) begin
      sample_in       = SB'(i);
      sample_in_valid = 1'b1;
      rst             = (i == 6);
      @(negedge mclk);
      if (i == 6) begin
        n_assert++;
        if (sample_out_valid !== 1'b0 || sample_out !== '0) begin
          n_fail++;
          $display("FAIL midreset_out: got valid %b data %0d expected valid 0 data 0",
                   sample_out_valid, sample_out);
        end
      end
    end
    rst             = 1'b0;
    sample_in_valid = 1'b0;
    drain();

    // Sample 5 was in flight and sample 6 arrived during reset: both are lost.
    n_assert++;
    if (out_log.size() != 8) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d expected 8", out_log.size());
    end

`ifndef VOLUME_ADJUST_RAMP_EN
    begin
      int exp_a[] = '{1, 2, 3, 4, 7, 8, 9, 10};
      foreach (exp_a[i]) begin
        int got = (i < out_log.size()) ? out_log[i] : -99999;
        n_assert++;
        if (got != exp_a[i]) begin
          n_fail++;
          $display("FAIL midreset[%0d]: got %0d expected %0d", i, got, exp_a[i]);
        end
      end
    end
`endif
  endtask

`ifdef VOLUME_ADJUST_RAMP_EN
  task automatic test_ramp();
    // Gain starts at 0 after reset and climbs one code per sample.
    int exp_a[] = '{0, 100, 200, 300, 400, 500, 600, 700, 800, 800, 800, 800,
                    800, 700, 600, 600};
    out_log.delete();
    volume = VB'(8);
    for (int i = 0; i < 16; i++) begin
      sample_in       = SB'(800);
      sample_in_valid = 1'b1;
      if (i == 12) volume = VB'(6);
      @(negedge mclk);
    end
    sample_in_valid = 1'b0;
    drain();

    n_assert++;
    if (out_log.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL ramp_count: got %0d expected %0d", out_log.size(), exp_a.size());
    end

    foreach (exp_a[i]) begin
      int got = (i < out_log.size()) ? out_log[i] : -99999;
      n_assert++;
      if (got != exp_a[i]) begin
        n_fail++;
        $display("FAIL ramp[%0d]: got %0d expected %0d", i, got, exp_a[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef VOLUME_ADJUST_RAMP_EN
    test_ramp();
`else
    test_unity();
    test_saturation();
    test_mute_truncation();
    test_same_cycle_volume();
`endif
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
